// File: rtl/demux1_n_hs_pkg.sv
// Shared types and sizing helpers for the 1-to-N handshake demultiplexer.
package demux1_n_hs_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N_OUT = 16;
    localparam int DEF_CNT_W = 16;

    // Select width for n channels; never below one bit so the port always exists.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux1_n_hs_if.sv
// Producer-side and consumer-side handshake bundle of demux1_n_hs.
interface demux1_n_hs_if
    import demux1_n_hs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_OUT = DEF_N_OUT,
    parameter int CNT_W = DEF_CNT_W
);
    localparam int SEL_W = sel_width(N_OUT);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_bcast;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic                   err_sel;
    logic [CNT_W-1:0]       xfer_cnt;
    logic [CNT_W-1:0]       drop_cnt;

    // Environment side: drives the producer word and the consumer ready lines.
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, err_sel, xfer_cnt, drop_cnt
    );

    // Demultiplexer side.
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, err_sel, xfer_cnt, drop_cnt
    );

endinterface

// File: rtl/demux1_n_hs_slot.sv
// One-entry output buffer: holds a word until its consumer takes it, and can
// drain and refill in the same cycle.
module demux1_n_hs_slot
    import demux1_n_hs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            EMPTY: begin
                if (load) state_d = FULL;
            end
            FULL: begin
                if (out_ready && !load) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        // Data only moves on a load, so an emptied slot keeps its last word.
        if (load) data_d = load_data;
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign free      = (state_q == EMPTY) | out_ready;

endmodule

// File: rtl/demux1_n_hs.sv
// Registered 1-to-N demultiplexer with valid/ready on the input and on every
// output, broadcast, illegal-select dropping and transfer/drop counters.
module demux1_n_hs
    import demux1_n_hs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_OUT = DEF_N_OUT,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    demux1_n_hs_if.slave  bus
);

    localparam int              SEL_W     = sel_width(N_OUT);
    localparam logic [SEL_W:0]  N_OUT_EXT = (SEL_W + 1)'(N_OUT);

    logic                   active_q, active_d;
    logic                   err_sel_q, err_sel_d;
    logic [CNT_W-1:0]       xfer_cnt_q, xfer_cnt_d;
    logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;

    logic [N_OUT-1:0]       slot_free;
    logic [N_OUT-1:0]       slot_load;
    logic [N_OUT-1:0]       slot_valid;
    logic [N_OUT*WIDTH-1:0] slot_data;
    logic                   sel_legal;
    logic                   in_ready;
    logic                   accept;

    // Input side decode. active_q keeps in_ready low through reset and until
    // the first edge after release, so no word lands during deassertion.
    always_comb begin
        sel_legal = ({1'b0, bus.in_sel} < N_OUT_EXT);
        in_ready  = 1'b0;
        if (active_q) begin
            if (bus.in_bcast)   in_ready = &slot_free;
            else if (sel_legal) in_ready = slot_free[bus.in_sel];
            else                in_ready = 1'b1;
        end
        accept = bus.in_valid & in_ready;
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slot
        assign slot_load[gi] = accept &
                               (bus.in_bcast | (sel_legal & (bus.in_sel == SEL_W'(gi))));

        demux1_n_hs_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (slot_load[gi]),
            .load_data (bus.in_data),
            .out_ready (bus.out_ready[gi]),
            .out_valid (slot_valid[gi]),
            .out_data  (slot_data[gi*WIDTH +: WIDTH]),
            .free      (slot_free[gi])
        );
    end

    always_comb begin
        active_d   = 1'b1;
        err_sel_d  = accept & ~bus.in_bcast & ~sel_legal;
        xfer_cnt_d = xfer_cnt_q + CNT_W'(accept);
        drop_cnt_d = drop_cnt_q;
        // Drop counter sticks at all-ones rather than wrapping.
        if (err_sel_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            err_sel_q  <= 1'b0;
            xfer_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            active_q   <= active_d;
            err_sel_q  <= err_sel_d;
            xfer_cnt_q <= xfer_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = slot_valid;
    assign bus.out_data  = slot_data;
    assign bus.err_sel   = err_sel_q;
    assign bus.xfer_cnt  = xfer_cnt_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule
